// File: rtl/imm_gen_stage.sv
// imm_gen_stage: pipelined immediate generator for the decode stage.
//
// Decodes the immediate of a 32-bit RV instruction according to a 3-bit
// format select, sign-extends it to XLEN and delivers it one cycle later
// together with a sideband tag through a 2-entry skid buffer (main register M
// plus skid register K).
//
// Optional feature macro: IMM_GEN_ZIMM_EN
//   defined     -> immsrc 101 selects the CSR zimm format (zero-extended
//                  instr[19:15])
//   not defined -> immsrc 101 is an illegal select
//
// Parameters:
//   XLEN  - output immediate width, 32 or 64
//   TAG_W - sideband tag width
//
// Ports:
//   clk, rst_n   - rising-edge clock, asynchronous active-low reset
//   flush        - synchronous flush, empties the stage
//   in_valid     - upstream offers an instruction
//   in_ready     - stage can accept this cycle (depends on state only)
//   in_instr     - instruction word
//   in_immsrc    - immediate format select
//   in_tag       - sideband tag
//   out_valid    - out_immext/out_tag/out_err are valid
//   out_ready    - downstream accepts
//   out_immext   - extended immediate
//   out_tag      - tag of the same entry
//   out_err      - entry had an illegal immsrc

module imm_gen_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_immext,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e state_q;

    logic [31:0]      imm32;
    logic             imm_err;
    logic [XLEN-1:0]  imm_ext;

    logic [XLEN-1:0]  m_imm_q, k_imm_q;
    logic [TAG_W-1:0] m_tag_q, k_tag_q;
    logic             m_err_q, k_err_q;

    logic accept;
    logic pop;

    // ------------------------------------------------------------------
    // Combinational immediate decode
    // ------------------------------------------------------------------
    always_comb begin
        imm32   = '0;
        imm_err = 1'b0;
        case (in_immsrc)
            3'b000: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            3'b001: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            3'b010: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
            3'b011: imm32 = {in_instr[31:12], 12'b0};
            3'b100: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
`ifdef IMM_GEN_ZIMM_EN
            3'b101: imm32 = {27'b0, in_instr[19:15]};
`endif
            default: begin
                imm32   = '0;
                imm_err = 1'b1;
            end
        endcase
    end

    // zimm has bit 31 clear, so sign-extension already yields its zero-extension.
    if (XLEN > 32) begin : g_wide
        assign imm_ext = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_narrow
        assign imm_ext = imm32;
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign out_valid = (state_q != StEmpty);
    assign in_ready  = (state_q != StFull);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_immext = m_imm_q;
    assign out_tag    = m_tag_q;
    assign out_err    = m_err_q;

    // ------------------------------------------------------------------
    // Skid buffer state machine and storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            m_imm_q <= '0;
            m_tag_q <= '0;
            m_err_q <= 1'b0;
            k_imm_q <= '0;
            k_tag_q <= '0;
            k_err_q <= 1'b0;
        end else if (flush) begin
            // Entries are invalidated; stale data in M/K is never presented as valid.
            state_q <= StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        m_imm_q <= imm_ext;
                        m_tag_q <= in_tag;
                        m_err_q <= imm_err;
                        state_q <= StOne;
                    end
                end
                StOne: begin
                    if (accept && pop) begin
                        m_imm_q <= imm_ext;
                        m_tag_q <= in_tag;
                        m_err_q <= imm_err;
                    end else if (accept) begin
                        k_imm_q <= imm_ext;
                        k_tag_q <= in_tag;
                        k_err_q <= imm_err;
                        state_q <= StFull;
                    end else if (pop) begin
                        state_q <= StEmpty;
                    end
                end
                StFull: begin
                    // in_ready is low here, so only the drain path exists.
                    if (pop) begin
                        m_imm_q <= k_imm_q;
                        m_tag_q <= k_tag_q;
                        m_err_q <= k_err_q;
                        state_q <= StOne;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage: one XLEN=32 and one XLEN=64 instance
// share the same stimulus and are compared against a queue-based reference.

module tb_imm_gen_stage;

    localparam int unsigned TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic [31:0]      in_instr;
    logic [2:0]       in_immsrc;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;

    logic             in_ready32, out_valid32, out_err32;
    logic [31:0]      out_immext32;
    logic [TAG_W-1:0] out_tag32;
    logic             in_ready64, out_valid64, out_err64;
    logic [63:0]      out_immext64;
    logic [TAG_W-1:0] out_tag64;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready32),
        .in_instr   (in_instr),
        .in_immsrc  (in_immsrc),
        .in_tag     (in_tag),
        .out_valid  (out_valid32),
        .out_ready  (out_ready),
        .out_immext (out_immext32),
        .out_tag    (out_tag32),
        .out_err    (out_err32)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready64),
        .in_instr   (in_instr),
        .in_immsrc  (in_immsrc),
        .in_tag     (in_tag),
        .out_valid  (out_valid64),
        .out_ready  (out_ready),
        .out_immext (out_immext64),
        .out_tag    (out_tag64),
        .out_err    (out_err64)
    );

    typedef struct {
        logic [63:0]      imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    entry_t exp_q[$];
    int     n_cmp = 0;
    int     n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference immediate, built arithmetically from the field definitions.
    function automatic void ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                    output logic [63:0] imm, output logic err);
        longint v;
        v   = 0;
        err = 1'b0;
        case (src)
            3'd0: v = longint'($signed(ins)) >>> 20;
            3'd1: v = ((longint'($signed(ins)) >>> 25) * 32) + longint'(ins[11:7]);
            3'd2: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                      + longint'(ins[11:8]) * 2 - (ins[31] ? 64'sd4096 : 64'sd0);
            3'd3: v = longint'($signed(ins & 32'hFFFF_F000));
            3'd4: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                      + longint'(ins[30:21]) * 2 - (ins[31] ? 64'sd1048576 : 64'sd0);
`ifdef IMM_GEN_ZIMM_EN
            3'd5: v = longint'(ins[19:15]);
`endif
            default: begin
                v   = 0;
                err = 1'b1;
            end
        endcase
        imm = 64'(v);
    endfunction

    task automatic check_outputs();
        check_eq("in_ready32", in_ready32, exp_q.size() < 2);
        check_eq("in_ready64", in_ready64, exp_q.size() < 2);
        check_eq("out_valid32", out_valid32, exp_q.size() > 0);
        check_eq("out_valid64", out_valid64, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            check_eq("immext32", out_immext32, exp_q[0].imm[31:0]);
            check_eq("immext64", out_immext64, exp_q[0].imm);
            check_eq("tag32", out_tag32, exp_q[0].tag);
            check_eq("tag64", out_tag64, exp_q[0].tag);
            check_eq("err32", out_err32, exp_q[0].err);
            check_eq("err64", out_err64, exp_q[0].err);
        end
    endtask

    // One clock: check at negedge, drive, then advance the model at posedge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [2:0] src,
                         input logic [TAG_W-1:0] tg, input logic ordy, input logic fl);
        logic   acc, pp;
        entry_t e;
        @(negedge clk);
        check_outputs();
        in_valid  = v;
        in_instr  = ins;
        in_immsrc = src;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
        acc = v && (exp_q.size() < 2);
        pp  = ordy && (exp_q.size() > 0);
        ref_imm(ins, src, e.imm, e.err);
        e.tag = tg;
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (pp) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(e);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid32"}, out_valid32, 1'b0);
        check_eq({tag, "_valid64"}, out_valid64, 1'b0);
        check_eq({tag, "_ready32"}, in_ready32, 1'b1);
        check_eq({tag, "_ready64"}, in_ready64, 1'b1);
        check_eq({tag, "_imm32"}, out_immext32, 64'h0);
        check_eq({tag, "_imm64"}, out_immext64, 64'h0);
        check_eq({tag, "_tag"}, out_tag32, 64'h0);
        check_eq({tag, "_err"}, out_err32, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_immsrc = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // I-type
        cycle(1'b1, 32'hFFF0_0093, 3'b000, 5'd1, 1'b1, 1'b0);
        #1;
        check_eq("i_valid", out_valid32, 1'b1);
        check_eq("i_imm32", out_immext32, 64'hFFFF_FFFF);
        check_eq("i_imm64", out_immext64, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("i_tag", out_tag32, 64'd1);

        // B/U/J back to back
        cycle(1'b1, 32'hFE00_0EE3, 3'b010, 5'd2, 1'b1, 1'b0);
        #1 check_eq("b_imm32", out_immext32, 64'hFFFF_FFFC);
        cycle(1'b1, 32'h1234_50B7, 3'b011, 5'd3, 1'b1, 1'b0);
        #1 check_eq("u_imm32", out_immext32, 64'h1234_5000);
        cycle(1'b1, 32'h0010_00EF, 3'b100, 5'd4, 1'b1, 1'b0);
        #1 check_eq("j_imm32", out_immext32, 64'h0000_0800);
        check_eq("j_ready", in_ready32, 1'b1);

        // Illegal and optional formats
        cycle(1'b1, 32'h1234_5678, 3'b110, 5'd5, 1'b1, 1'b0);
        #1 check_eq("ill_err", out_err32, 1'b1);
        check_eq("ill_imm", out_immext32, 64'h0);
        cycle(1'b1, 32'h0007_D073, 3'b101, 5'd6, 1'b1, 1'b0);
        #1;
`ifdef IMM_GEN_ZIMM_EN
        check_eq("z_imm64", out_immext64, 64'h0000_0000_0000_000F);
        check_eq("z_err", out_err64, 1'b0);
`else
        check_eq("z_imm64", out_immext64, 64'h0);
        check_eq("z_err", out_err64, 1'b1);
`endif
        cycle(1'b0, 32'h0, 3'b000, 5'd0, 1'b1, 1'b0);

        // Backpressure: tags 1,2 taken, 3 held, then drain in order
        cycle(1'b1, 32'h0010_0093, 3'b000, 5'd1, 1'b0, 1'b0);
        cycle(1'b1, 32'h0020_0093, 3'b000, 5'd2, 1'b0, 1'b0);
        #1 check_eq("bp_ready", in_ready32, 1'b0);
        cycle(1'b1, 32'h0030_0093, 3'b000, 5'd3, 1'b0, 1'b0);
        cycle(1'b1, 32'h0030_0093, 3'b000, 5'd3, 1'b1, 1'b0);
        #1 check_eq("bp_tag2", out_tag32, 64'd2);
        cycle(1'b1, 32'h0030_0093, 3'b000, 5'd3, 1'b1, 1'b0);
        #1 check_eq("bp_tag3", out_tag32, 64'd3);
        cycle(1'b0, 32'h0, 3'b000, 5'd0, 1'b1, 1'b0);

        // Flush while full with an offered input
        cycle(1'b1, 32'h0010_0093, 3'b000, 5'd7, 1'b0, 1'b0);
        cycle(1'b1, 32'h0020_0093, 3'b000, 5'd8, 1'b0, 1'b0);
        cycle(1'b1, 32'h0030_0093, 3'b000, 5'd9, 1'b0, 1'b1);
        #1 check_eq("fl_valid", out_valid32, 1'b0);
        check_eq("fl_ready", in_ready32, 1'b1);
        cycle(1'b0, 32'h0, 3'b000, 5'd0, 1'b1, 1'b0);

        // Asynchronous reset while full
        cycle(1'b1, 32'hFFF0_0093, 3'b000, 5'd10, 1'b0, 1'b0);
        cycle(1'b1, 32'hFFF0_0093, 3'b000, 5'd11, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("arst");
        exp_q.delete();
        #1 rst_n = 1'b1;
        cycle(1'b1, 32'h8000_0037, 3'b011, 5'd12, 1'b0, 1'b0);
        #1 check_eq("post_rst_imm64", out_immext64, 64'hFFFF_FFFF_8000_0000);
        check_eq("post_rst_tag", out_tag64, 64'd12);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
                  TAG_W'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 3'b000, 5'd0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Pipelined, parametrised immediate generator for the decode stage.
- Accepts a 32-bit instruction, an immediate-format select and a sideband tag over a valid/ready handshake.
- Emits the sign-extended XLEN-bit immediate one cycle later through a 2-entry skid buffer.
- Covers all RV32 formats (I, S, B, U, J) and flags illegal selects, for XLEN 32 or 64.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 5, width of sideband tag (e.g. rd or ROB index) carried alongside each immediate.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_instr  input  32  instruction word.
- in_immsrc  input  3  format select.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  out_immext, out_tag and out_err are valid.
- out_ready  input  1  downstream accepts.
- out_immext  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag of the same entry.
- out_err  output  1  entry had an illegal immsrc.

Behaviour:
- Encodings; every result is sign-extended from bit 31 to XLEN unless stated otherwise:
  - 000 I: instr[31:20].
  - 001 S: {instr[31:25], instr[11:7]}.
  - 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 011 U: {instr[31:12], 12'b0}.
  - 100 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 101: Z format, only with the optional feature below.
  - All other codes: immext = 0, err = 1.
- Storage: main output register (M) and skid register (K), each holding {immext, tag, err}.
- State machine:
  - EMPTY: M and K invalid.
  - ONE: M valid.
  - FULL: M and K valid.
- Outputs:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL); decoded from the state register only, with no combinational path from out_ready.
  - out_* always driven from M.
- Transfers: accept = in_valid & in_ready; pop = out_valid & out_ready.
- Transitions:
  - EMPTY: accept -> ONE, M loaded.
  - ONE:
    - accept & pop -> ONE, M reloaded.
    - accept & !pop -> FULL, K loaded.
    - pop & !accept -> EMPTY.
  - FULL:
    - pop -> ONE, M <= K. No accept is possible in FULL.
- Latency: 1 cycle. An accepted instruction is visible on out_* on the next cycle when the stage was EMPTY, or when ONE with a simultaneous pop.
- Ordering: strict FIFO; no entry is dropped or duplicated.
- Immediate logic is computed combinationally from in_* and registered on accept.
- flush:
  - Next state is EMPTY; M and K are invalidated.
  - A same-cycle accept is discarded; a same-cycle pop is still considered to have occurred downstream.
  - flush has priority over all transitions.
- Reset (asynchronous, any state, mid-transfer):
  - state = EMPTY, out_valid = 0, in_ready = 1, out_immext = 0, out_tag = 0, out_err = 0.
  - M and K data cleared to 0.
- XLEN=64: upper 32 bits are copies of bit 31 of the 32-bit result; Z format is zero-extended.
- out_immext/out_tag/out_err hold stable while out_valid & !out_ready.

Optional Feature:
- Macro: IMM_GEN_ZIMM_EN.
- Defined: immsrc 101 selects the CSR zimm format, immext = zero-extended instr[19:15], err = 0.
- Not defined: 101 is illegal, immext = 0, err = 1.
- The macro affects no other behaviour.

Test Plan:
- I-type, XLEN=32: instr 0xFFF00093, immsrc 000, tag 1, out_ready=1 -> next cycle out_valid=1, immext 0xFFFFFFFF, tag 1, err 0. Repeat with XLEN=64 -> 0xFFFFFFFFFFFFFFFF.
- B/U/J, back-to-back, out_ready=1:
  - 0xFE000EE3 (010) -> 0xFFFFFFFC.
  - 0x123450B7 (011) -> 0x12345000.
  - 0x001000EF (100) -> 0x00000800.
  - Expect one result per cycle, in order, in_ready held 1.
- Backpressure: out_ready=0, offer tags 1, 2, 3:
  - Tags 1 and 2 accepted; in_ready=0 from the cycle after the second accept; tag 3 held.
  - Raise out_ready -> outputs 1, 2, 3 in order with no loss.
- Illegal/optional: immsrc 110 -> immext 0, err 1. instr 0x0007D073 with immsrc 101 -> 0x0000000F, err 0 with IMM_GEN_ZIMM_EN; immext 0, err 1 without.
- Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed input never appears on the output.
- rst_n pulsed low asynchronously while FULL -> immediately out_valid=0, out_immext=0, in_ready=1; first post-reset accept appears after 1 cycle.
